// File: rtl/instr_fetch_unit_pkg.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit_pkg
// Shared definitions for the instruction fetch stage and its neighbours (PC
// register, decode): word width, fetch FSM state encoding, PC increment,
// reset PC and a helper that word-aligns an address.
// ---------------------------------------------------------------------------
package instr_fetch_unit_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        FULL = 2'd2
    } fetch_state_e;

    localparam word_t PC_INC   = 32'd4;
    localparam word_t RESET_PC = 32'h0000_0000;

    // Instructions are word aligned; the low two bits of a target are dropped.
    function automatic word_t align_word(input word_t addr);
        return {addr[WORD_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_watchdog.sv
// ---------------------------------------------------------------------------
// fetch_watchdog
// 8-bit saturating cycle counter with a sticky expiry flag. Counts while
// `en` is high, returns to zero on `clr`, stops at TIMEOUT. The flag sets on
// the edge where the count reaches TIMEOUT and only `rst` clears it.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   synchronous active-high reset
//   clr      in   clear the counter (flag unaffected)
//   en       in   count one cycle
//   expired  out  sticky, count has reached TIMEOUT
// ---------------------------------------------------------------------------
module fetch_watchdog #(
    parameter logic [7:0] TIMEOUT = 8'd255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [7:0] count;

    // NOTE: clocked state is written with non-blocking assignments so every
    // register samples the pre-edge values, independent of block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            count   <= '0;
            expired <= 1'b0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != TIMEOUT)) begin
            count <= count + 8'd1;
            if (count == (TIMEOUT - 8'd1)) begin
                expired <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
// Fetch stage between the PC register and decode. Requests the word at `pc`
// from a variable-latency instruction memory, captures it in the instruction
// register and hands it to decode over valid/ready. Drives `pc_next` back to
// the PC register (which loads every cycle), applies branch/jump redirects,
// flags misaligned redirect targets and runs a memory-timeout watchdog.
//
// Ports:
//   clk              in   system clock, rising edge
//   startin          in   synchronous active-high reset
//   pc               in   current PC register value
//   pc_next          out  value the PC register loads at the next edge
//   imem_req         out  memory request (high in REQ)
//   imem_addr        out  memory address (always `pc`)
//   imem_ack         in   one-cycle ack, `imem_rdata` valid with it
//   imem_rdata       in   instruction word
//   redirect         in   taken branch/jump
//   redirect_target  in   new fetch address
//   ir               out  instruction register
//   ir_pc            out  address of the instruction in `ir`
//   ir_valid         out  `ir`/`ir_pc` hold a valid instruction
//   ir_ready         in   decode accepts the instruction
//   misalign_err     out  sticky, a redirect target was not word aligned
//   fetch_timeout    out  sticky, memory did not ack within TIMEOUT cycles
// ---------------------------------------------------------------------------
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [7:0] TIMEOUT = 8'd255
) (
    input  logic              clk,
    input  logic              startin,
    input  logic [WORD_W-1:0] pc,
    output logic [WORD_W-1:0] pc_next,
    output logic              imem_req,
    output logic [WORD_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [WORD_W-1:0] imem_rdata,
    input  logic              redirect,
    input  logic [WORD_W-1:0] redirect_target,
    output logic [WORD_W-1:0] ir,
    output logic [WORD_W-1:0] ir_pc,
    output logic              ir_valid,
    input  logic              ir_ready,
    output logic              misalign_err,
    output logic              fetch_timeout
);

    fetch_state_e state;
    logic         in_req;
    logic         fetch_done;

    assign in_req     = (state == REQ);
    // An ack that coincides with a redirect is dropped.
    assign fetch_done = in_req && imem_ack && !redirect;

    assign imem_addr = pc;

    // NOTE: every output of this block is given a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        imem_req = in_req;
        pc_next  = pc;
        if (!startin) begin
            if (redirect) begin
                pc_next = align_word(redirect_target);
            end else if (fetch_done) begin
                pc_next = pc + PC_INC;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (startin) begin
            state        <= IDLE;
            ir           <= '0;
            ir_pc        <= '0;
            ir_valid     <= 1'b0;
            misalign_err <= 1'b0;
        end else if (redirect) begin
            // A transfer in FULL with ir_ready in this cycle still counts;
            // decode is responsible for squashing it.
            state    <= REQ;
            ir_valid <= 1'b0;
            if (redirect_target[1:0] != 2'b00) begin
                misalign_err <= 1'b1;
            end
        end else begin
            case (state)
                IDLE: state <= REQ;
                REQ: begin
                    if (imem_ack) begin
                        ir       <= imem_rdata;
                        ir_pc    <= pc;
                        ir_valid <= 1'b1;
                        state    <= FULL;
                    end
                end
                FULL: begin
                    if (ir_ready) begin
                        ir_valid <= 1'b0;
                        state    <= REQ;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The counter runs only while waiting in REQ; ack, redirect or being in
    // any other state restarts it from zero.
    fetch_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst     (startin),
        .clr     (!in_req || imem_ack || redirect),
        .en      (in_req),
        .expired (fetch_timeout)
    );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_unit
// Directed scenarios followed by a randomized run against a transaction-level
// reference model. The bench owns the PC register (loads pc_next every edge)
// and an instruction memory whose contents are a fixed function of address.
// ---------------------------------------------------------------------------
module tb_instr_fetch_unit;
    import instr_fetch_unit_pkg::*;

    logic  clk = 1'b0;
    logic  startin = 1'b1;
    word_t pc = RESET_PC;
    word_t pc_next;
    logic  imem_req;
    word_t imem_addr;
    logic  imem_ack = 1'b0;
    word_t imem_rdata = '0;
    logic  redirect = 1'b0;
    word_t redirect_target = '0;
    word_t ir;
    word_t ir_pc;
    logic  ir_valid;
    logic  ir_ready = 1'b0;
    logic  misalign_err;
    logic  fetch_timeout;

    int    checks = 0;
    int    errors = 0;
    word_t last_word;

    always #5 clk = ~clk;

    // PC register: reset to RESET_PC, otherwise loads pc_next every cycle.
    always @(posedge clk) pc <= startin ? RESET_PC : pc_next;

    instr_fetch_unit dut (
        .clk             (clk),
        .startin         (startin),
        .pc              (pc),
        .pc_next         (pc_next),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .ir              (ir),
        .ir_pc           (ir_pc),
        .ir_valid        (ir_valid),
        .ir_ready        (ir_ready),
        .misalign_err    (misalign_err),
        .fetch_timeout   (fetch_timeout)
    );

    function automatic word_t mem_word(input word_t a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic test_reset();
        startin = 1'b1;
        repeat (2) @(negedge clk);
        startin = 1'b0;
        #1;
        checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL reset_ir_valid got %0b exp 0", ir_valid); end
        checks++; if (ir !== 32'h0) begin errors++; $display("FAIL reset_ir got %h exp 0", ir); end
        checks++; if (ir_pc !== 32'h0) begin errors++; $display("FAIL reset_ir_pc got %h exp 0", ir_pc); end
        checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL reset_misalign got %0b exp 0", misalign_err); end
        checks++; if (fetch_timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got %0b exp 0", fetch_timeout); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_idle_req got %0b exp 0", imem_req); end
        checks++; if (pc_next !== RESET_PC) begin errors++; $display("FAIL reset_pc_next got %h exp %h", pc_next, RESET_PC); end
    endtask

    task automatic test_zero_wait();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            imem_ack = 1'b1; imem_rdata = mem_word(pc); ir_ready = 1'b1;
            #1;
            checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL zw_req[%0d] got %0b exp 1", i, imem_req); end
            checks++; if (imem_addr !== word_t'(4 * i)) begin errors++; $display("FAIL zw_addr[%0d] got %h exp %h", i, imem_addr, 4 * i); end
            checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL zw_valid_low[%0d] got %0b exp 0", i, ir_valid); end
            checks++; if (pc_next !== word_t'(4 * i + 4)) begin errors++; $display("FAIL zw_pc_next[%0d] got %h exp %h", i, pc_next, 4 * i + 4); end
            @(negedge clk);
            imem_ack = 1'b0;
            #1;
            checks++; if (ir_valid !== 1'b1) begin errors++; $display("FAIL zw_valid_high[%0d] got %0b exp 1", i, ir_valid); end
            checks++; if (ir_pc !== word_t'(4 * i)) begin errors++; $display("FAIL zw_ir_pc[%0d] got %h exp %h", i, ir_pc, 4 * i); end
            checks++; if (ir !== mem_word(word_t'(4 * i))) begin errors++; $display("FAIL zw_ir[%0d] got %h exp %h", i, ir, mem_word(word_t'(4 * i))); end
            checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL zw_full_req[%0d] got %0b exp 0", i, imem_req); end
        end
    endtask

    task automatic test_wait_states();
        @(negedge clk);
        redirect = 1'b1; redirect_target = 32'h40; ir_ready = 1'b0;
        #1;
        checks++; if (pc_next !== 32'h40) begin errors++; $display("FAIL ws_redirect_pc_next got %h exp 40", pc_next); end
        @(negedge clk);
        redirect = 1'b0;
        for (int w = 0; w < 3; w++) begin
            #1;
            checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin errors++; $display("FAIL ws_req[%0d] got req %0b addr %h exp 1 40", w, imem_req, imem_addr); end
            checks++; if (pc_next !== 32'h40) begin errors++; $display("FAIL ws_hold[%0d] got %h exp 40", w, pc_next); end
            @(negedge clk);
        end
        last_word = $urandom;
        imem_ack = 1'b1; imem_rdata = last_word;
        #1;
        checks++; if (pc_next !== 32'h44) begin errors++; $display("FAIL ws_ack_pc_next got %h exp 44", pc_next); end
        @(negedge clk);
        imem_ack = 1'b0;
        #1;
        checks++; if (ir !== last_word || ir_pc !== 32'h40 || ir_valid !== 1'b1) begin
            errors++; $display("FAIL ws_capture got ir %h pc %h v %0b exp %h 40 1", ir, ir_pc, ir_valid, last_word);
        end
    endtask

    task automatic test_backpressure();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            checks++; if (ir_valid !== 1'b1 || ir !== last_word) begin errors++; $display("FAIL bp_hold[%0d] got v %0b ir %h exp 1 %h", c, ir_valid, ir, last_word); end
            checks++; if (imem_req !== 1'b0 || pc_next !== 32'h44) begin errors++; $display("FAIL bp_idle[%0d] got req %0b pc_next %h exp 0 44", c, imem_req, pc_next); end
        end
        @(negedge clk);
        ir_ready = 1'b1;
        @(negedge clk);
        ir_ready = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h44 || ir_valid !== 1'b0) begin
            errors++; $display("FAIL bp_release got req %0b addr %h v %0b exp 1 44 0", imem_req, imem_addr, ir_valid);
        end
    endtask

    task automatic test_redirect_collision();
        @(negedge clk);
        redirect = 1'b1; redirect_target = 32'h100; imem_ack = 1'b1; imem_rdata = $urandom;
        #1;
        checks++; if (pc_next !== 32'h100) begin errors++; $display("FAIL rc_pc_next got %h exp 100", pc_next); end
        @(negedge clk);
        redirect = 1'b0; imem_ack = 1'b0;
        #1;
        checks++; if (ir_valid !== 1'b0 || ir !== last_word) begin errors++; $display("FAIL rc_discard got v %0b ir %h exp 0 %h", ir_valid, ir, last_word); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin errors++; $display("FAIL rc_refetch got req %0b addr %h exp 1 100", imem_req, imem_addr); end
        checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL rc_aligned_flag got %0b exp 0", misalign_err); end
        @(negedge clk);
        redirect = 1'b1; redirect_target = 32'h102; imem_ack = 1'b1; imem_rdata = $urandom;
        #1;
        checks++; if (pc_next !== 32'h100) begin errors++; $display("FAIL rc_mis_pc_next got %h exp 100", pc_next); end
        @(negedge clk);
        redirect = 1'b0; imem_ack = 1'b0;
        #1;
        checks++; if (imem_addr !== 32'h100 || ir_valid !== 1'b0 || ir !== last_word) begin
            errors++; $display("FAIL rc_mis_refetch got addr %h v %0b ir %h exp 100 0 %h", imem_addr, ir_valid, ir, last_word);
        end
        checks++; if (misalign_err !== 1'b1) begin errors++; $display("FAIL rc_misalign got %0b exp 1", misalign_err); end
        // Redirect while decode accepts in FULL.
        @(negedge clk);
        imem_ack = 1'b1; imem_rdata = mem_word(pc);
        @(negedge clk);
        imem_ack = 1'b0; ir_ready = 1'b1; redirect = 1'b1; redirect_target = 32'h200;
        #1;
        checks++; if (ir_valid !== 1'b1 || ir_pc !== 32'h100 || pc_next !== 32'h200) begin
            errors++; $display("FAIL rc_full got v %0b ir_pc %h pc_next %h exp 1 100 200", ir_valid, ir_pc, pc_next);
        end
        @(negedge clk);
        redirect = 1'b0; ir_ready = 1'b0;
        #1;
        checks++; if (ir_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200 || misalign_err !== 1'b1) begin
            errors++; $display("FAIL rc_full_after got v %0b req %0b addr %h mis %0b exp 0 1 200 1", ir_valid, imem_req, imem_addr, misalign_err);
        end
    endtask

    task automatic test_wrap();
        @(negedge clk);
        redirect = 1'b1; redirect_target = 32'hFFFF_FFFC;
        @(negedge clk);
        redirect = 1'b0; imem_ack = 1'b1; imem_rdata = mem_word(pc);
        #1;
        checks++; if (imem_addr !== 32'hFFFF_FFFC || pc_next !== 32'h0) begin
            errors++; $display("FAIL wrap_pc_next got addr %h pc_next %h exp FFFFFFFC 0", imem_addr, pc_next);
        end
        @(negedge clk);
        imem_ack = 1'b0; ir_ready = 1'b1;
        #1;
        checks++; if (ir_pc !== 32'hFFFF_FFFC || ir !== mem_word(32'hFFFF_FFFC) || ir_valid !== 1'b1) begin
            errors++; $display("FAIL wrap_capture got pc %h ir %h v %0b", ir_pc, ir, ir_valid);
        end
        @(negedge clk);
        ir_ready = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_next got req %0b addr %h exp 1 0", imem_req, imem_addr); end
    endtask

    task automatic test_timeout();
        // Already in the first REQ cycle at pc 0, no ack will come.
        for (int k = 1; k <= 255; k++) begin
            checks++; if (fetch_timeout !== 1'b0) begin errors++; $display("FAIL to_early[%0d] got %0b exp 0", k, fetch_timeout); end
            @(negedge clk);
            #1;
        end
        checks++; if (fetch_timeout !== 1'b1 || imem_req !== 1'b1) begin errors++; $display("FAIL to_set got %0b req %0b exp 1 1", fetch_timeout, imem_req); end
        redirect = 1'b1; redirect_target = 32'h10;
        @(negedge clk);
        redirect = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (fetch_timeout !== 1'b1) begin errors++; $display("FAIL to_sticky got %0b exp 1", fetch_timeout); end
    endtask

    task automatic test_reset_in_full();
        @(negedge clk);
        imem_ack = 1'b1; imem_rdata = mem_word(pc);
        @(negedge clk);
        imem_ack = 1'b0;
        #1;
        checks++; if (ir_valid !== 1'b1 || ir_pc !== 32'h10) begin errors++; $display("FAIL rf_full got v %0b pc %h exp 1 10", ir_valid, ir_pc); end
        @(negedge clk);
        startin = 1'b1;
        @(negedge clk);
        startin = 1'b0;
        #1;
        checks++; if (ir_valid !== 1'b0 || ir !== 32'h0 || ir_pc !== 32'h0) begin errors++; $display("FAIL rf_clear got v %0b ir %h pc %h exp 0 0 0", ir_valid, ir, ir_pc); end
        checks++; if (fetch_timeout !== 1'b0 || misalign_err !== 1'b0) begin errors++; $display("FAIL rf_flags got to %0b mis %0b exp 0 0", fetch_timeout, misalign_err); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rf_idle got %0b exp 0", imem_req); end
        @(negedge clk);
        #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin errors++; $display("FAIL rf_first_req got %0b addr %h exp 1 %h", imem_req, imem_addr, RESET_PC); end
        // Reset while an ack arrives in REQ: the ack is ignored.
        @(negedge clk);
        startin = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        startin = 1'b0; imem_ack = 1'b0;
        #1;
        checks++; if (ir_valid !== 1'b0 || ir !== 32'h0 || imem_req !== 1'b0) begin errors++; $display("FAIL rr_ack_ignored got v %0b ir %h req %0b exp 0 0 0", ir_valid, ir, imem_req); end
    endtask

    // Model: tracks whether an instruction is held for decode, the address of
    // that instruction, the next address to fetch and the post-reset settle
    // cycle. A request is outstanding whenever nothing is held and the settle
    // cycle is over.
    task automatic test_random();
        bit    m_valid, m_idle, m_mis, exp_req, acked;
        word_t m_fetch, m_pc, exp_next, tgt;
        @(negedge clk);
        startin = 1'b1; redirect = 1'b0; imem_ack = 1'b0; ir_ready = 1'b0;
        @(negedge clk);
        startin = 1'b0;
        m_valid = 1'b0; m_idle = 1'b1; m_mis = 1'b0; m_fetch = RESET_PC; m_pc = '0;
        for (int n = 0; n < 400; n++) begin
            exp_req  = !m_valid && !m_idle;
            redirect = ($urandom_range(11) == 0);
            tgt      = $urandom;
            if ($urandom_range(3) != 0) tgt[1:0] = 2'b00;
            redirect_target = tgt;
            acked      = exp_req && ($urandom_range(2) != 0);
            imem_ack   = acked;
            imem_rdata = mem_word(pc);
            ir_ready   = $urandom_range(1);
            exp_next   = redirect ? align_word(tgt) : (acked ? m_fetch + PC_INC : m_fetch);
            #1;
            checks++; if (imem_req !== exp_req) begin errors++; $display("FAIL rnd_req[%0d] got %0b exp %0b", n, imem_req, exp_req); end
            if (exp_req) begin
                checks++; if (imem_addr !== m_fetch) begin errors++; $display("FAIL rnd_addr[%0d] got %h exp %h", n, imem_addr, m_fetch); end
            end
            checks++; if (pc_next !== exp_next) begin errors++; $display("FAIL rnd_pc_next[%0d] got %h exp %h", n, pc_next, exp_next); end
            checks++; if (ir_valid !== m_valid) begin errors++; $display("FAIL rnd_valid[%0d] got %0b exp %0b", n, ir_valid, m_valid); end
            if (m_valid) begin
                checks++; if (ir_pc !== m_pc || ir !== mem_word(m_pc)) begin errors++; $display("FAIL rnd_ir[%0d] got %h@%h exp %h@%h", n, ir, ir_pc, mem_word(m_pc), m_pc); end
            end
            checks++; if (misalign_err !== m_mis || fetch_timeout !== 1'b0) begin errors++; $display("FAIL rnd_flags[%0d] got mis %0b to %0b exp %0b 0", n, misalign_err, fetch_timeout, m_mis); end
            m_idle = 1'b0;
            if (redirect) begin
                if (tgt[1:0] != 2'b00) m_mis = 1'b1;
                m_valid = 1'b0;
                m_fetch = align_word(tgt);
            end else if (m_valid) begin
                if (ir_ready) m_valid = 1'b0;
            end else if (acked) begin
                m_valid = 1'b1;
                m_pc    = m_fetch;
                m_fetch = m_fetch + PC_INC;
            end
            @(negedge clk);
        end
        redirect = 1'b0; imem_ack = 1'b0; ir_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_backpressure();
        test_redirect_collision();
        test_wrap();
        test_timeout();
        test_reset_in_full();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage directly downstream of the PC register: consumes the current `pc` and drives `pc_next` back into the PC register input, which loads every cycle with no enable.
- Issues requests to an instruction memory with variable latency over a req/ack handshake.
- Holds the fetched word in an instruction register and presents it to decode with a valid/ready handshake.
- Handles branch/jump redirects, misalignment detection and a memory-timeout watchdog.

Parameters:
- PC_INC, 4, increment applied to `pc` after a successful fetch.
- RESET_PC, 32'h0000_0000, value the PC register takes on reset; used as the first fetch address.
- TIMEOUT, 255, number of REQ cycles without `imem_ack` before `fetch_timeout` sets; counter is 8 bits wide.

Ports:
- clk  in  1  single system clock, rising edge.
- startin  in  1  synchronous active-high reset (same net that resets the PC register).
- pc  in  32  current PC register output.
- pc_next  out  32  value the PC register loads at the next edge.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  32  fetch address; equals `pc` whenever `imem_req` is 1.
- imem_ack  in  1  one-cycle pulse; `imem_rdata` is valid in the same cycle.
- imem_rdata  in  32  instruction word.
- redirect  in  1  taken branch/jump from execute.
- redirect_target  in  32  new fetch address.
- ir  out  32  instruction register to decode.
- ir_pc  out  32  address of the instruction held in `ir`.
- ir_valid  out  1  `ir` and `ir_pc` hold a valid instruction.
- ir_ready  in  1  decode accepts the instruction; a transfer occurs when `ir_valid & ir_ready`.
- misalign_err  out  1  sticky; a redirect target had bits [1:0] != 0.
- fetch_timeout  out  1  sticky; watchdog expired.

Behaviour:
Reset, sampled on the `clk` edge:
- State goes to IDLE.
- `ir`, `ir_pc`, `ir_valid`, `imem_req`, `misalign_err`, `fetch_timeout` and the watchdog counter all go to 0.
- `pc_next` drives `pc` combinationally; the PC register resets itself, so this value is a don't-care.

FSM states are IDLE, REQ and FULL. Outputs `imem_req` and `pc_next` are combinational from state and inputs. All other outputs are registered.

IDLE:
- `imem_req` = 0, `pc_next` = `pc`.
- Goes to REQ unconditionally after one cycle, which lets the PC settle after reset.

REQ:
- `imem_req` = 1, `imem_addr` = `pc`.
- If `imem_ack`: `ir` <= `imem_rdata`, `ir_pc` <= `pc`, `ir_valid` <= 1, `pc_next` = `pc` + PC_INC, go to FULL.
- Otherwise: `pc_next` = `pc`, stay in REQ, watchdog counter increments.
- Minimum fetch latency is 1 cycle (ack in the first REQ cycle).

FULL:
- `imem_req` = 0, `pc_next` = `pc`.
- On `ir_ready`: `ir_valid` <= 0, go to REQ.
- Sustained throughput is 1 instruction per 2 cycles with zero-wait memory.

Redirect (IDLE, REQ or FULL, not in reset):
- `redirect` has priority over all other transitions.
- `pc_next` = {`redirect_target`[31:2], 2'b00}; `ir_valid` <= 0; go to REQ; watchdog counter clears.
- An `imem_ack` in the same cycle is discarded; `ir` is not updated.
- In FULL, `ir_ready` together with `redirect` still counts as a completed transfer (decode owns squashing it); the redirect is then applied as above.
- If `redirect_target`[1:0] != 0, `misalign_err` <= 1.

Memory contract:
- The address is paired with the ack in the same cycle.
- Memory treats a change of `imem_addr` while `imem_req` stays 1 as abandonment of the old request.

Arithmetic:
- PC increment is modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000, with no flag.

Watchdog:
- The counter counts only in REQ and clears on ack, on redirect and on leaving REQ.
- When the counter reaches TIMEOUT, `fetch_timeout` <= 1 (sticky). The FSM keeps waiting in REQ.
- The counter saturates at TIMEOUT.

Reset mid-operation (e.g. in REQ or FULL):
- Returns to IDLE next edge and clears all state.
- A pending ack in the reset cycle is ignored.

Decomposition:
- Shared package holds:
  - FSM state encoding constants (IDLE = 2'd0, REQ = 2'd1, FULL = 2'd2).
  - PC_INC.
  - RESET_PC.
  - The 32-bit word width constant, reused by the PC register and decode.
- One natural sub-module, `fetch_watchdog`: an 8-bit saturating counter with clear/enable inputs and a sticky flag output.
- The FSM, IR and next-PC mux stay in the top block.

Test Plan:
- Reset then zero-wait memory: `startin` for 2 cycles, `pc` = 0, ack in each REQ cycle, `ir_ready` = 1 -> `ir_pc` sequence 0, 4, 8 with `ir_valid` high every 2nd cycle.
- Wait states: ack 3 cycles after `imem_req` rises at `pc` = 32'h40 -> `pc_next` holds 32'h40 for 3 cycles, then 32'h44; `ir` = `imem_rdata` at the ack cycle.
- Decode backpressure: `ir_ready` = 0 for 5 cycles in FULL -> `ir_valid` stays 1, `ir` stable, `imem_req` = 0, `pc_next` = `pc` throughout.
- Redirect colliding with ack in REQ: `redirect_target` = 32'h100 -> `ir_valid` stays 0, next request at 32'h100; `redirect_target` = 32'h102 -> fetch at 32'h100 and `misalign_err` = 1.
- Wrap and timeout: `pc` = 32'hFFFF_FFFC with ack -> `pc_next` = 0; never ack -> `fetch_timeout` = 1 on the 255th REQ cycle and stays 1 until `startin`.
- Reset in FULL: `startin` pulse -> `ir_valid` = 0, `ir` = 0, IDLE for one cycle, then `imem_req` = 1 at `pc` = 0.
